serial_frame_tx: RTL and testbench

- Transmit side of the single-bit serial `num` stream consumed by the team's sequence checker.
- Accepts a parallel data word with a valid/ready handshake.
- Serializes it MSB-first as one frame on `num`: fixed preamble, data bits, optional even-parity bit.
- Exposes the current bit index and a hold input so the bench or upstream logic can stall the line.

---
 rtl/serial_frame_tx.sv | 155 +++++++++++++++
 tb/tb_serial_frame_tx.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_frame_tx.sv
// serial_frame_tx
//   Turns one parallel word into one frame on the single-bit line `num`.
//   The frame is a fixed preamble, then the data MSB first, then an optional
//   even-parity bit. Each bit lasts one cycle unless `hold` stretches it.
//
// Ports
//   clk      in   clock, rising edge
//   rst      in   synchronous reset, active high
//   data_in  in   word to send, captured when valid && ready
//   valid    in   upstream has a word
//   ready    out  combinational, high while idle
//   hold     in   freezes the frame in progress for one cycle per cycle high
//   num      out  registered serial bit
//   num_cnt  out  registered bit index inside the current field
//   busy     out  registered, high while a frame is on the line
//   done     out  registered one-cycle pulse after the last bit of a frame
module serial_frame_tx #(
   parameter int unsigned      DATA_W    = 8,
   parameter int unsigned      PRE_W     = 4,
   parameter logic [PRE_W-1:0] PREAMBLE  = 4'b1011,
   parameter bit               PARITY_EN = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] data_in,
   input  logic              valid,
   output logic              ready,
   input  logic              hold,
   output logic              num,
   output logic [3:0]        num_cnt,
   output logic              busy,
   output logic              done
);

   if (DATA_W < 1 || DATA_W > 16 || PRE_W < 1 || PRE_W > 16) begin : g_bad_width
      $error("serial_frame_tx: DATA_W and PRE_W must lie in 1..16");
   end

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] PRE  = 2'd1;
   localparam logic [1:0] DATA = 2'd2;
   localparam logic [1:0] PAR  = 2'd3;

   localparam logic [3:0] PRE_LAST  = 4'(PRE_W - 1);
   localparam logic [3:0] DATA_LAST = 4'(DATA_W - 1);

   logic [1:0]        state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [DATA_W-1:0] shift_q, shift_d;
   logic [PRE_W-1:0]  pre_q, pre_d;
   logic              par_q, par_d;
   logic              num_q, num_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   assign ready   = (state_q == IDLE);
   assign num     = num_q;
   assign num_cnt = cnt_q;
   assign busy    = busy_q;
   assign done    = done_q;

   // Outputs are registered, so the next-state logic also computes the bit
   // that must appear on the line once the new state is entered. The current
   // bit always sits in the MSB of its shift register.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      shift_d = shift_q;
      pre_d   = pre_q;
      par_d   = par_q;
      num_d   = num_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            num_d  = 1'b0;
            cnt_d  = 4'd0;
            busy_d = 1'b0;
            if (valid) begin
               state_d = PRE;
               shift_d = data_in;
               par_d   = ^data_in;
               pre_d   = PREAMBLE;
               num_d   = PREAMBLE[PRE_W-1];
               busy_d  = 1'b1;
            end
         end
         PRE: begin
            if (!hold) begin
               if (cnt_q == PRE_LAST) begin
                  state_d = DATA;
                  cnt_d   = 4'd0;
                  num_d   = shift_q[DATA_W-1];
               end else begin
                  pre_d = pre_q << 1;
                  cnt_d = cnt_q + 4'd1;
                  num_d = pre_d[PRE_W-1];
               end
            end
         end
         DATA: begin
            if (!hold) begin
               if (cnt_q == DATA_LAST) begin
                  cnt_d = 4'd0;
                  if (PARITY_EN) begin
                     state_d = PAR;
                     num_d   = par_q;
                  end else begin
                     state_d = IDLE;
                     num_d   = 1'b0;
                     busy_d  = 1'b0;
                     done_d  = 1'b1;
                  end
               end else begin
                  shift_d = shift_q << 1;
                  cnt_d   = cnt_q + 4'd1;
                  num_d   = shift_d[DATA_W-1];
               end
            end
         end
         default: begin // PAR: single bit, then back to idle
            if (!hold) begin
               state_d = IDLE;
               cnt_d   = 4'd0;
               num_d   = 1'b0;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         shift_q <= '0;
         pre_q   <= '0;
         par_q   <= 1'b0;
         num_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         shift_q <= shift_d;
         pre_q   <= pre_d;
         par_q   <= par_d;
         num_q   <= num_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

endmodule

// File: tb/tb_serial_frame_tx.sv
// Bench for serial_frame_tx: two instances (parity on / parity off) share
// the stimulus. A frame-list model predicts every output each cycle; a few
// directed frames are also compared against hand-written bit patterns.
module tb_serial_frame_tx;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, valid, hold;
   logic [7:0] data_in;
   wire  [1:0] ready_v, num_v, busy_v, done_v;
   wire  [1:0][3:0] cnt_v;

   serial_frame_tx #(.DATA_W(8), .PRE_W(4), .PREAMBLE(4'b1011), .PARITY_EN(1'b1)) dut0 (
      .clk(clk), .rst(rst), .data_in(data_in), .valid(valid), .ready(ready_v[0]),
      .hold(hold), .num(num_v[0]), .num_cnt(cnt_v[0]), .busy(busy_v[0]), .done(done_v[0]));
   serial_frame_tx #(.DATA_W(8), .PRE_W(4), .PREAMBLE(4'b1011), .PARITY_EN(1'b0)) dut1 (
      .clk(clk), .rst(rst), .data_in(data_in), .valid(valid), .ready(ready_v[1]),
      .hold(hold), .num(num_v[1]), .num_cnt(cnt_v[1]), .busy(busy_v[1]), .done(done_v[1]));

   int nvec = 0, nerr = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- model: each frame is a list of (bit, index) pairs ----
   logic [3:0] pre_pat = 4'b1011;
   bit         mb [2][32];
   logic [3:0] mc [2][32];
   int         mlen [2] = '{0, 0};
   int         mpos [2] = '{0, 0};
   bit         mdone[2] = '{0, 0};
   bit         macc [2] = '{0, 0};
   bit         chk_en = 0;

   // Advance model i across the coming rising edge using the current inputs.
   function automatic void mstep(input int i);
      bit nd = 0;
      int n = 0;
      macc[i] = 0;
      if (rst) begin
         mlen[i] = 0; mpos[i] = 0;
      end else if (mpos[i] < mlen[i]) begin
         if (!hold) begin
            mpos[i]++;
            if (mpos[i] == mlen[i]) nd = 1;
         end
      end else if (valid) begin
         for (int p = 0; p < 4; p++) begin mb[i][n] = pre_pat[3-p]; mc[i][n] = 4'(p); n++; end
         for (int d = 0; d < 8; d++) begin mb[i][n] = data_in[7-d]; mc[i][n] = 4'(d); n++; end
         if (i == 0) begin mb[i][n] = ^data_in; mc[i][n] = 4'd0; n++; end
         mlen[i] = n; mpos[i] = 0; macc[i] = 1;
      end
      mdone[i] = nd;
   endfunction

   always @(negedge clk) begin
      if (chk_en) begin
         for (int i = 0; i < 2; i++) begin
            bit eb;
            eb = mpos[i] < mlen[i];
            chk($sformatf("num%0d", i),   64'(num_v[i]),   64'(eb ? mb[i][mpos[i]] : 1'b0));
            chk($sformatf("cnt%0d", i),   64'(cnt_v[i]),   64'(eb ? mc[i][mpos[i]] : 4'd0));
            chk($sformatf("busy%0d", i),  64'(busy_v[i]),  64'(eb));
            chk($sformatf("ready%0d", i), 64'(ready_v[i]), 64'(!eb));
            chk($sformatf("done%0d", i),  64'(done_v[i]),  64'(mdone[i]));
         end
         mstep(0);
         mstep(1);
      end
   end

   // ---------------- capture helpers for the literal checks ----------------
   logic [63:0] sn[2], sd[2], sb[2], sc[2];
   logic        cn[2][40], cd[2][40], cb[2][40], cr[2][40];
   logic [3:0]  cc[2][40];

   task automatic cap(input int n);
      for (int i = 0; i < 2; i++) begin sn[i] = '0; sd[i] = '0; sb[i] = '0; sc[i] = '0; end
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         for (int i = 0; i < 2; i++) begin
            sn[i] = {sn[i][62:0], num_v[i]};
            sd[i] = {sd[i][62:0], done_v[i]};
            sb[i] = {sb[i][62:0], busy_v[i]};
            sc[i] = {sc[i][59:0], cnt_v[i]};
            cn[i][k] = num_v[i]; cd[i][k] = done_v[i]; cb[i][k] = busy_v[i];
            cr[i][k] = ready_v[i]; cc[i][k] = cnt_v[i];
         end
      end
   endtask

   // Returns just after the edge at which dut0 takes the word.
   task automatic wait_acc();
      bit ok = 0;
      for (int t = 0; t < 200 && !ok; t++) begin
         @(negedge clk); #1;
         ok = macc[0];
      end
      if (!ok) begin
         nvec++; nerr++;
         $display("FAIL accept_timeout: no accept within 200 cycles");
      end
      @(posedge clk); #1;
   endtask

   task automatic send(input logic [7:0] d);
      data_in = d; valid = 1'b1;
      wait_acc();
      valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   int frames;

   initial begin
      rst = 1'b1; valid = 1'b0; hold = 1'b0; data_in = '0;
      @(posedge clk); #1;
      chk_en = 1;
      idle(1);
      rst = 1'b0;
      idle(2);

      // A5: plain frame on both instances
      send(8'hA5); cap(14);
      chk("a5_num0",  sn[0], 64'(14'b10111010010100));
      chk("a5_num1",  sn[1], 64'(14'b10111010010100));
      chk("a5_done0", sd[0], 64'(14'b00000000000001));
      chk("a5_done1", sd[1], 64'(14'b00000000000010));
      chk("a5_busy0", sb[0], 64'(14'h3FFE));
      chk("a5_busy1", sb[1], 64'(14'h3FFC));
      chk("a5_cnt0",  sc[0], 64'h0001230123456700);
      idle(3);

      // 07: parity bit is 1
      send(8'h07); cap(14);
      chk("07_num0", sn[0], 64'(14'b10110000011110));
      chk("07_num1", sn[1], 64'(14'b10110000011100));
      chk("07_done1", sd[1], 64'(14'b00000000000010));
      idle(3);

      // A5 with hold for 3 cycles on data bit 2
      send(8'hA5);
      fork
         cap(17);
         begin
            idle(6); hold = 1'b1;
            idle(3); hold = 1'b0;
         end
      join
      chk("hold_num0",  sn[0], 64'(17'h17794));
      chk("hold_num1",  sn[1], 64'(17'h17794));
      chk("hold_done0", sd[0], 64'(17'h00001));
      chk("hold_done1", sd[1], 64'(17'h00002));
      chk("hold_busy0", sb[0], 64'(17'h1FFFE));
      chk("hold_cnt6",  64'(cc[0][6]),  64'd2);
      chk("hold_cnt9",  64'(cc[0][9]),  64'd2);
      chk("hold_cnt10", 64'(cc[0][10]), 64'd3);
      idle(3);

      // reset while data bit 5 is on the line
      send(8'hA5);
      fork
         cap(14);
         begin
            idle(9); rst = 1'b1;
            idle(1); rst = 1'b0;
         end
      join
      chk("rst_num0",   sn[0], 64'(14'b10111010010000));
      chk("rst_done0",  sd[0], 64'd0);
      chk("rst_done1",  sd[1], 64'd0);
      chk("rst_busy0",  sb[0], 64'(14'b11111111110000));
      chk("rst_cnt9",   64'(cc[0][9]),  64'd5);
      chk("rst_cnt10",  64'(cc[0][10]), 64'd0);
      chk("rst_ready9", 64'(cr[0][9]),  64'd0);
      chk("rst_ready10",64'(cr[0][10]), 64'd1);
      send(8'h5A); cap(14);
      chk("post_rst_num0",  sn[0], 64'(14'b10110101101000));
      chk("post_rst_done0", sd[0], 64'(14'b00000000000001));
      idle(3);

      // back-to-back: valid stays high across two words
      data_in = 8'h3C; valid = 1'b1;
      wait_acc();
      fork
         cap(32);
         begin
            data_in = 8'hC3;
            wait_acc();
            valid = 1'b0;
         end
      join
      chk("b2b_ndone0", 64'($countones(sd[0][31:0])), 64'd2);
      chk("b2b_ndone1", 64'($countones(sd[1][31:0])), 64'd2);
      chk("b2b_gap_num",  64'(cn[0][13]), 64'd0);
      chk("b2b_gap_busy", 64'(cb[0][13]), 64'd0);
      chk("b2b_gap_done", 64'(cd[0][13]), 64'd1);
      chk("b2b_restart",  64'(cb[0][14]), 64'd1);
      chk("b2b_done2",    64'(cd[0][27]), 64'd1);
      chk("b2b_done2_p0", 64'(cd[1][25]), 64'd1);
      idle(3);

      // random words with random hold, checked cycle by cycle by the model
      frames = 0;
      for (int cyc = 0; cyc < 80000 && frames < 2000; cyc++) begin
         @(posedge clk); #1;
         hold = ($urandom_range(0, 4) == 0);
         if (valid && macc[0]) begin valid = 1'b0; frames++; end
         if (!valid && frames < 2000 && $urandom_range(0, 1) == 0) begin
            data_in = 8'($urandom); valid = 1'b1;
         end
      end
      valid = 1'b0; hold = 1'b0;
      chk("random_frames", 64'(frames), 64'd2000);
      idle(20);

      chk_en = 0;
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
